// File: rtl/sequenced_decoder.sv
// Registered one-hot address decoder with LATCH, PULSE and SCAN modes.
// Commands use a valid/ready handshake; abort and synchronous reset cancel any activity.
module sequenced_decoder #(
  parameter int ADDR_WIDTH = 2,
  parameter int PULSE_LEN  = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      address,
  input  logic                       enable,
  input  logic [1:0]                 mode,
  input  logic                       abort,
  output logic [(1<<ADDR_WIDTH)-1:0] out,
  output logic [ADDR_WIDTH-1:0]      cur_addr,
  output logic                       busy,
  output logic                       done
);

  localparam int OUTPUTS = 1 << ADDR_WIDTH;
  localparam int CW      = $clog2(PULSE_LEN + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_PULSE = 2'd2,
    S_SCAN  = 2'd3
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [ADDR_WIDTH-1:0] steps;
  logic [ADDR_WIDTH-1:0] next_addr;

  function automatic logic [OUTPUTS-1:0] onehot(input logic [ADDR_WIDTH-1:0] a);
    onehot    = '0;
    onehot[a] = 1'b1;
  endfunction

  assign in_ready  = !busy;
  // Wraps naturally from OUTPUTS-1 to 0 because the width is exactly ADDR_WIDTH.
  assign next_addr = cur_addr + ADDR_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      out      <= '0;
      cur_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      steps    <= '0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state    <= S_IDLE;
        out      <= '0;
        cur_addr <= '0;
        busy     <= 1'b0;
      end else begin
        case (state)
          S_PULSE: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              state    <= S_IDLE;
              out      <= '0;
              cur_addr <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
          S_SCAN: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (steps != '0) begin
              cur_addr <= next_addr;
              out      <= onehot(next_addr);
              cnt      <= CW'(PULSE_LEN - 1);
              steps    <= steps - ADDR_WIDTH'(1);
            end else begin
              state    <= S_IDLE;
              out      <= '0;
              cur_addr <= '0;
              busy     <= 1'b0;
              done     <= 1'b1;
            end
          end
          default: begin
            // IDLE and LATCH both accept; LATCH is replaced with no gap cycle.
            if (in_valid) begin
              if (!enable || mode == 2'd3) begin
                state    <= S_IDLE;
                out      <= '0;
                cur_addr <= '0;
              end else begin
                out      <= onehot(address);
                cur_addr <= address;
                cnt      <= CW'(PULSE_LEN - 1);
                steps    <= '1;
                case (mode)
                  2'd1:    begin state <= S_PULSE; busy <= 1'b1; end
                  2'd2:    begin state <= S_SCAN;  busy <= 1'b1; end
                  default: state <= S_LATCH;
                endcase
              end
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequenced_decoder.sv
// Scoreboard bench for sequenced_decoder: a trace-level reference model queues the expected
// per-cycle outputs, and a negedge monitor pops and compares them against the DUT.
module tb_sequenced_decoder;

  localparam int AW = 2;
  localparam int PL = 3;
  localparam int N  = 1 << AW;

  typedef struct packed {
    logic [N-1:0]  o;
    logic [AW-1:0] a;
    logic          b;
    logic          d;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n, in_valid, enable, abort;
  logic          in_ready, busy, done;
  logic [AW-1:0] address, cur_addr;
  logic [1:0]    mode;
  logic [N-1:0]  out;

  sequenced_decoder #(.ADDR_WIDTH(AW), .PULSE_LEN(PL)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .address(address), .enable(enable), .mode(mode), .abort(abort),
    .out(out), .cur_addr(cur_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  exp_t plan[$];
  exp_t hold = '0;
  exp_t curv = '0;
  exp_t mon_e;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;

  function automatic logic [N-1:0] oh(input logic [AW-1:0] x);
    oh    = '0;
    oh[x] = 1'b1;
  endfunction

  // Model: a started PULSE/SCAN expands into its full cycle-by-cycle trace up front.
  task automatic drive(input logic v, input logic [AW-1:0] a, input logic e,
                       input logic [1:0] m, input logic ab, input logic rn);
    exp_t          nx;
    logic [AW-1:0] ad;
    int unsigned   lines;
    in_valid = v; address = a; enable = e; mode = m; abort = ab; reset_n = rn;
    if (!rn || ab) begin
      plan.delete();
      hold = '0;
      nx   = '0;
    end else if (curv.b) begin
      nx = plan.pop_front();
      if (plan.size() == 0) hold = '0;
    end else if (v) begin
      if (!e || m == 2'd3) begin
        hold = '0;
        nx   = '0;
      end else if (m == 2'd0) begin
        hold = '{o: oh(a), a: a, b: 1'b0, d: 1'b0};
        nx   = hold;
      end else begin
        lines = (m == 2'd1) ? 1 : N;
        for (int unsigned k = 0; k < lines; k++) begin
          ad = AW'((int'(a) + k) % N);
          for (int unsigned j = 0; j < PL; j++)
            plan.push_back('{o: oh(ad), a: ad, b: 1'b1, d: 1'b0});
        end
        plan.push_back('{o: '0, a: '0, b: 1'b0, d: 1'b1});
        nx   = plan.pop_front();
        hold = '0;
      end
    end else begin
      nx = hold;
    end
    curv = nx;
    sb.push_back(nx);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, 2'd0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    cyc++;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      vectors++;
      if ({out, cur_addr, busy, done} !== mon_e || in_ready !== !mon_e.b) begin
        miscompares++;
        $display("FAIL outputs @cycle %0d: got out=%b cur_addr=%0d busy=%b done=%b in_ready=%b, expected out=%b cur_addr=%0d busy=%b done=%b in_ready=%b",
                 cyc, out, cur_addr, busy, done, in_ready,
                 mon_e.o, mon_e.a, mon_e.b, mon_e.d, !mon_e.b);
      end
    end
  end

  initial begin
    // Reset then LATCH sweep 2 -> 3 with no gap
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    drive(1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b1);
    idle(2);
    // PULSE addr 1, next command held on in_valid through busy
    drive(1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) drive(1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 1'b1);
    idle(5);
    // Full SCAN from 2 with wrap
    drive(1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 1'b1);
    idle(14);
    // Abort mid-SCAN with a command presented in the same cycle
    drive(1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 1'b1);
    idle(3);
    drive(1'b1, 2'd1, 1'b1, 2'd0, 1'b1, 1'b1);
    idle(3);
    // Clear and reserved mode
    drive(1'b1, 2'd2, 1'b1, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1);
    drive(1'b1, 2'd1, 1'b1, 2'd3, 1'b0, 1'b1);
    idle(2);
    // Reset mid-PULSE
    drive(1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 1'b1);
    idle(1);
    drive(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0);
    idle(5);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      drive(1'b1 & ($urandom_range(1) == 1), AW'($urandom_range(N - 1)),
            ($urandom_range(4) != 0), 2'($urandom_range(3)),
            ($urandom_range(19) == 0), ($urandom_range(59) != 0));
    idle(2);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected entries left, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
